// File: rtl/palette_anim_sequencer.sv
// palette_anim_sequencer
//   Generates the palette-scroll offset used by the image controller
//   (block = f(x,y) - offset). A small command engine selects forward,
//   reverse, ping-pong, pause or single-step animation. A programmable
//   frame divider sets the step rate. Offset only moves on a frame edge,
//   so the picture never tears mid-frame.
// Ports
//   CLK_IN, RST_IN     clock, synchronous active-high reset
//   FRAME_CLOCK        async frame level; a rising edge marks frame start
//   cmd_valid/ready    1-deep command slot handshake
//   cmd_op, cmd_arg    opcode / argument of the command
//   offset             current palette offset
//   offset_update      1-cycle pulse on every offset write
//   mode, ping_dir     current animation mode / ping-pong direction
module palette_anim_sequencer #(
  parameter int OFFSET_W    = 8,
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic                FRAME_CLOCK,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [OFFSET_W-1:0] cmd_arg,
  output logic [OFFSET_W-1:0] offset,
  output logic                offset_update,
  output logic [1:0]          mode,
  output logic                ping_dir
);

  localparam logic [1:0] M_PAUSE = 2'd0;
  localparam logic [1:0] M_FWD   = 2'd1;
  localparam logic [1:0] M_REV   = 2'd2;
  localparam logic [1:0] M_PING  = 2'd3;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_DIV = 3'd1;
  localparam logic [2:0] OP_FWD     = 3'd2;
  localparam logic [2:0] OP_REV     = 3'd3;
  localparam logic [2:0] OP_PAUSE   = 3'd4;
  localparam logic [2:0] OP_SET_OFF = 3'd5;
  localparam logic [2:0] OP_PING    = 3'd6;
  localparam logic [2:0] OP_STEP    = 3'd7;

  localparam logic [OFFSET_W-1:0] OFF_ONE = OFFSET_W'(1);
  localparam logic [OFFSET_W-1:0] OFF_MAX = '1;

  // Frame-edge synchroniser; reset to 1 so a level already high at
  // reset release does not look like a fresh frame start.
  logic s1_q, s2_q, s3_q;
  logic fe;

  logic                pend_q, pend_d;
  logic [2:0]          pend_op_q, pend_op_d;
  logic [OFFSET_W-1:0] pend_arg_q, pend_arg_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                upd_q, upd_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;

  assign fe = s2_q & ~s3_q;

  always_comb begin
    pend_d     = pend_q;
    pend_op_d  = pend_op_q;
    pend_arg_d = pend_arg_q;
    offset_d   = offset_q;
    upd_d      = 1'b0;
    mode_d     = mode_q;
    dir_d      = dir_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;

    if (fe) begin
      if (pend_q) begin
        // A frame that applies a command never takes a divider step.
        pend_d    = 1'b0;
        div_cnt_d = '0;
        case (pend_op_q)
          OP_SET_DIV: div_d  = pend_arg_q[DIV_W-1:0];
          OP_FWD:     mode_d = M_FWD;
          OP_REV:     mode_d = M_REV;
          OP_PAUSE:   mode_d = M_PAUSE;
          OP_SET_OFF: begin offset_d = pend_arg_q; upd_d = 1'b1; end
          OP_PING:    begin mode_d = M_PING; dir_d = 1'b0; end
          OP_STEP:    begin offset_d = offset_q + OFF_ONE; upd_d = 1'b1; end
          default:    ; // NOP
        endcase
      end else if (mode_q != M_PAUSE) begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          upd_d     = 1'b1;
          case (mode_q)
            M_FWD: offset_d = offset_q + OFF_ONE;
            M_REV: offset_d = offset_q - OFF_ONE;
            default: begin
              // Ping-pong bounces off the ends without repeating them.
              if (!dir_q) begin
                if (offset_q == OFF_MAX) begin
                  dir_d = 1'b1; offset_d = OFF_MAX - OFF_ONE;
                end else offset_d = offset_q + OFF_ONE;
              end else begin
                if (offset_q == '0) begin
                  dir_d = 1'b0; offset_d = OFF_ONE;
                end else offset_d = offset_q - OFF_ONE;
              end
            end
          endcase
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
    end

    // Slot is only free when nothing is pending, so a command accepted
    // on a frame-edge cycle waits for the following frame.
    if (cmd_valid && !pend_q) begin
      pend_d     = 1'b1;
      pend_op_d  = cmd_op;
      pend_arg_d = cmd_arg;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      pend_q     <= 1'b0;
      pend_op_q  <= OP_NOP;
      pend_arg_q <= '0;
      offset_q   <= '0;
      upd_q      <= 1'b0;
      mode_q     <= M_FWD;
      dir_q      <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      div_cnt_q  <= '0;
    end else begin
      s1_q       <= FRAME_CLOCK;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      pend_q     <= pend_d;
      pend_op_q  <= pend_op_d;
      pend_arg_q <= pend_arg_d;
      offset_q   <= offset_d;
      upd_q      <= upd_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  assign cmd_ready     = ~pend_q;
  assign offset        = offset_q;
  assign offset_update = upd_q;
  assign mode          = mode_q;
  assign ping_dir      = dir_q;

endmodule

// File: tb/tb_palette_anim_sequencer.sv
module tb_palette_anim_sequencer;
  logic       CLK_IN = 1'b0;
  logic       RST_IN = 1'b1;
  logic       FRAME_CLOCK = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic [7:0] offset;
  logic       offset_update;
  logic [1:0] mode;
  logic       ping_dir;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  palette_anim_sequencer #(.OFFSET_W(8), .DIV_W(4), .DEFAULT_DIV(5)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .FRAME_CLOCK(FRAME_CLOCK),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .offset(offset), .offset_update(offset_update),
    .mode(mode), .ping_dir(ping_dir)
  );

  always #5 CLK_IN = ~CLK_IN;

  always @(negedge CLK_IN) if (offset_update === 1'b1) pulse_cnt++;

  // All tasks start and end on a falling clock edge.
  task automatic do_reset();
    RST_IN = 1'b1;
    repeat (2) @(negedge CLK_IN);
    RST_IN = 1'b0;
    @(negedge CLK_IN);
  endtask

  task automatic frame();
    FRAME_CLOCK = 1'b1;
    repeat (4) @(negedge CLK_IN);
    FRAME_CLOCK = 1'b0;
    repeat (4) @(negedge CLK_IN);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready === 1'b1) begin
        @(negedge CLK_IN);
        ok = 1;
        break;
      end
      @(negedge CLK_IN);
    end
    cmd_valid = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL send_timeout op=%0d cmd_ready stuck at %b, want 1", op, cmd_ready); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (offset !== 8'd0) begin fails++; $display("FAIL rst_offset got %0d want 0", offset); end
    tests++; if (mode !== 2'd1) begin fails++; $display("FAIL rst_mode got %0d want 1", mode); end
    tests++; if (ping_dir !== 1'b0) begin fails++; $display("FAIL rst_dir got %b want 0", ping_dir); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    tests++; if (offset_update !== 1'b0) begin fails++; $display("FAIL rst_upd got %b want 0", offset_update); end
  endtask

  task automatic test_default_div();
    do_reset();
    pulse_cnt = 0;
    repeat (5) frame();
    tests++; if (offset !== 8'd0) begin fails++; $display("FAIL t1_f5 got %0d want 0", offset); end
    frame();
    tests++; if (offset !== 8'd1) begin fails++; $display("FAIL t1_f6 got %0d want 1", offset); end
    repeat (6) frame();
    tests++; if (offset !== 8'd2) begin fails++; $display("FAIL t1_f12 got %0d want 2", offset); end
    tests++; if (pulse_cnt !== 2) begin fails++; $display("FAIL t1_pulses got %0d want 2", pulse_cnt); end
  endtask

  task automatic test_reverse();
    do_reset();
    send(3'd1, 8'd0);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL t2_ready_low got %b want 0", cmd_ready); end
    frame();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL t2_ready_back got %b want 1", cmd_ready); end
    tests++; if (offset !== 8'd0) begin fails++; $display("FAIL t2_apply_div got %0d want 0", offset); end
    send(3'd3, 8'd0);
    frame();
    tests++; if (offset !== 8'd0 || mode !== 2'd2) begin fails++; $display("FAIL t2_apply_rev got off=%0d mode=%0d want 0/2", offset, mode); end
    frame();
    tests++; if (offset !== 8'd255) begin fails++; $display("FAIL t2_wrap got %0d want 255", offset); end
    frame();
    tests++; if (offset !== 8'd254) begin fails++; $display("FAIL t2_rev2 got %0d want 254", offset); end
  endtask

  task automatic test_ping();
    logic [7:0] exp_off [4];
    logic       exp_dir [4];
    exp_off = '{8'd254, 8'd255, 8'd254, 8'd253};
    exp_dir = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    send(3'd1, 8'd0); frame();
    pulse_cnt = 0;
    send(3'd5, 8'd253); frame();
    tests++; if (offset !== 8'd253 || pulse_cnt !== 1) begin fails++; $display("FAIL t3_setoff got off=%0d pulses=%0d want 253/1", offset, pulse_cnt); end
    send(3'd6, 8'd0); frame();
    tests++; if (mode !== 2'd3 || offset !== 8'd253) begin fails++; $display("FAIL t3_ping_apply got mode=%0d off=%0d want 3/253", mode, offset); end
    for (int i = 0; i < 4; i++) begin
      frame();
      tests++;
      if (offset !== exp_off[i] || ping_dir !== exp_dir[i]) begin
        fails++; $display("FAIL t3_up_%0d got off=%0d dir=%b want %0d/%b", i, offset, ping_dir, exp_off[i], exp_dir[i]);
      end
    end
    send(3'd5, 8'd1); frame();
    tests++; if (offset !== 8'd1 || ping_dir !== 1'b1) begin fails++; $display("FAIL t3_set1 got off=%0d dir=%b want 1/1", offset, ping_dir); end
    frame();
    tests++; if (offset !== 8'd0 || ping_dir !== 1'b1) begin fails++; $display("FAIL t3_down0 got off=%0d dir=%b want 0/1", offset, ping_dir); end
    frame();
    tests++; if (offset !== 8'd1 || ping_dir !== 1'b0) begin fails++; $display("FAIL t3_bounce got off=%0d dir=%b want 1/0", offset, ping_dir); end
  endtask

  task automatic test_pause_step();
    do_reset();
    send(3'd1, 8'd0); frame();
    send(3'd4, 8'd0); frame();
    pulse_cnt = 0;
    repeat (5) frame();
    tests++; if (offset !== 8'd0 || pulse_cnt !== 0) begin fails++; $display("FAIL t4_pause got off=%0d pulses=%0d want 0/0", offset, pulse_cnt); end
    send(3'd7, 8'd0); frame();
    tests++; if (offset !== 8'd1 || pulse_cnt !== 1) begin fails++; $display("FAIL t4_step got off=%0d pulses=%0d want 1/1", offset, pulse_cnt); end
    tests++; if (mode !== 2'd0) begin fails++; $display("FAIL t4_mode got %0d want 0", mode); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(3'd1, 8'd0); frame();
    // Raise the frame level, then present a command exactly in the fe cycle.
    FRAME_CLOCK = 1'b1;
    repeat (2) @(negedge CLK_IN);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 8'd0;
    @(negedge CLK_IN);
    cmd_valid = 1'b0;
    tests++; if (offset !== 8'd1 || mode !== 2'd1 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL t5_same_fe got off=%0d mode=%0d rdy=%b want 1/1/0", offset, mode, cmd_ready); end
    // Second request held while the slot is busy.
    cmd_valid = 1'b1; cmd_op = 3'd4;
    FRAME_CLOCK = 1'b0;
    repeat (4) @(negedge CLK_IN);
    tests++; if (cmd_ready !== 1'b0 || mode !== 2'd1) begin fails++; $display("FAIL t5_held got rdy=%b mode=%0d want 0/1", cmd_ready, mode); end
    FRAME_CLOCK = 1'b1;
    repeat (2) @(negedge CLK_IN);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL t5_pre_apply got rdy=%b want 0", cmd_ready); end
    @(negedge CLK_IN);
    tests++; if (cmd_ready !== 1'b1 || mode !== 2'd2 || offset !== 8'd1 || offset_update !== 1'b0) begin
      fails++; $display("FAIL t5_apply got rdy=%b mode=%0d off=%0d upd=%b want 1/2/1/0", cmd_ready, mode, offset, offset_update); end
    @(negedge CLK_IN);
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL t5_second_acc got rdy=%b want 0", cmd_ready); end
    FRAME_CLOCK = 1'b0;
    repeat (4) @(negedge CLK_IN);
    frame();
    tests++; if (mode !== 2'd0 || offset !== 8'd1) begin fails++; $display("FAIL t5_pause got mode=%0d off=%0d want 0/1", mode, offset); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(3'd1, 8'd0); frame();
    send(3'd5, 8'd7); frame();
    send(3'd3, 8'd0);
    FRAME_CLOCK = 1'b1;
    @(negedge CLK_IN);
    do_reset();
    tests++; if (offset !== 8'd0 || mode !== 2'd1 || ping_dir !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL t6_reset got off=%0d mode=%0d dir=%b rdy=%b want 0/1/0/1", offset, mode, ping_dir, cmd_ready); end
    send(3'd5, 8'd9);
    pulse_cnt = 0;
    repeat (6) @(negedge CLK_IN);
    tests++; if (offset !== 8'd0 || pulse_cnt !== 0 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL t6_no_fe got off=%0d pulses=%0d rdy=%b want 0/0/0", offset, pulse_cnt, cmd_ready); end
    FRAME_CLOCK = 1'b0;
    repeat (4) @(negedge CLK_IN);
    FRAME_CLOCK = 1'b1;
    repeat (2) @(negedge CLK_IN);
    tests++; if (offset !== 8'd0 || offset_update !== 1'b0) begin fails++; $display("FAIL t6_lat2 got off=%0d upd=%b want 0/0", offset, offset_update); end
    @(negedge CLK_IN);
    tests++; if (offset !== 8'd9 || offset_update !== 1'b1) begin fails++; $display("FAIL t6_lat3 got off=%0d upd=%b want 9/1", offset, offset_update); end
    @(negedge CLK_IN);
    tests++; if (offset_update !== 1'b0 || mode !== 2'd1) begin fails++; $display("FAIL t6_after got upd=%b mode=%0d want 0/1", offset_update, mode); end
    FRAME_CLOCK = 1'b0;
    repeat (4) @(negedge CLK_IN);
  endtask

  initial begin
    @(negedge CLK_IN);
    test_reset();
    test_default_div();
    test_reverse();
    test_ping();
    test_pause_step();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
